alu_seq: RTL and testbench

Parametrised accumulator ALU that sits on the shared tri-state data bus as the datapath's arithmetic unit. It provides single-cycle load, add, subtract and logic operations, plus optional multi-cycle shift-add multiply and restoring divide. Every operation updates a status flag register, and a busy/done handshake is provided for the multi-cycle operations. An extension register holds the upper product half or the remainder.

---
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - control and status bundle of the alu_seq accumulator ALU
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       op;
  logic             write;
  logic             read;
  logic             read_ext;
  logic [WIDTH-1:0] Acc;
  logic [WIDTH-1:0] Ext;
  logic [3:0]       flags;
  logic             busy;
  logic             done;

  modport master (
    output op, write, read, read_ext,
    input  Acc, Ext, flags, busy, done
  );

  modport slave (
    input  op, write, read, read_ext,
    output Acc, Ext, flags, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - accumulator ALU on the shared tri-state data bus
// Define ALU_MULDIV_EN to build the shift-add multiplier, restoring divider and Ext register.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  inout  wire  [WIDTH-1:0] Dbus,
  alu_seq_if.slave         bus
);
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] ext_val;
  logic             busy_val, done_val;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH:0]   sc_sum, sc_dif;
  logic             sc_c, sc_v;
  logic             fin;
  logic [WIDTH-1:0] fin_acc;
  logic [3:0]       fin_flags;

  always_comb begin
    sc_sum = {1'b0, acc_q} + {1'b0, Dbus};
    sc_dif = {1'b0, acc_q} - {1'b0, Dbus};
    sc_res = Dbus;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_res = sc_sum[WIDTH-1:0];
        sc_c   = sc_sum[WIDTH];
        sc_v   = (acc_q[WIDTH-1] == Dbus[WIDTH-1]) && (sc_res[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sc_dif[WIDTH-1:0];
        sc_c   = sc_dif[WIDTH];
        sc_v   = (acc_q[WIDTH-1] != Dbus[WIDTH-1]) && (sc_res[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_AND:  sc_res = acc_q & Dbus;
      OP_OR:   sc_res = acc_q | Dbus;
      OP_XOR:  sc_res = acc_q ^ Dbus;
      default: sc_res = Dbus;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    flags_d = flags_q;
    if (bus.write && !busy_val && bus.op <= OP_XOR) begin
      acc_d   = sc_res;
      flags_d = {sc_res[WIDTH-1], sc_res == '0, sc_c, sc_v};
    end else if (fin) begin
      acc_d   = fin_acc;
      flags_d = fin_flags;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ext_q, ext_d;
  // hi/lo are private working registers so Acc/Ext never show partial results
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   step, shifted;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ext_d     = ext_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    done_d    = 1'b0;
    fin       = 1'b0;
    fin_acc   = '0;
    fin_flags = '0;
    step      = '0;
    shifted   = '0;
    case (state_q)
      IDLE: begin
        if (bus.write && bus.op[2:1] == 2'b11) begin
          state_d  = RUN;
          cnt_d    = '0;
          hi_d     = '0;
          lo_d     = acc_q;
          opb_d    = Dbus;
          is_div_d = bus.op[0];
        end
      end
      RUN: begin
        if (is_div_q) begin
          shifted = {hi_q, lo_q[WIDTH-1]};
          if (shifted >= {1'b0, opb_q}) begin
            step = shifted - {1'b0, opb_q};
            hi_d = step[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = shifted[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          step = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
          hi_d = step[WIDTH:1];
          lo_d = {step[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          ext_d     = hi_d;
          fin       = 1'b1;
          fin_acc   = lo_d;
          fin_flags = {lo_d[WIDTH-1], lo_d == '0,
                       !is_div_q && (hi_d != '0), is_div_q && (opb_q == '0)};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ext_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ext_q    <= ext_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
    end
  end

  assign ext_val  = ext_q;
  assign busy_val = (state_q == RUN);
  assign done_val = done_q;
`else
  assign ext_val   = '0;
  assign busy_val  = 1'b0;
  assign done_val  = 1'b0;
  assign fin       = 1'b0;
  assign fin_acc   = '0;
  assign fin_flags = '0;
`endif

  assign bus.Acc   = acc_q;
  assign bus.Ext   = ext_val;
  assign bus.flags = flags_q;
  assign bus.busy  = busy_val;
  assign bus.done  = done_val;

  // read_ext wins over read when both are asserted
  assign Dbus = (bus.read_ext || bus.read) ? (bus.read_ext ? ext_val : acc_q) : {WIDTH{1'bz}};
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
// Covers the MUL/DIV scenarios when ALU_MULDIV_EN is defined, the no-op behaviour otherwise.
module tb_alu_seq;
  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [7:0] drv = 8'h00;
  logic       drv_en = 1'b0;
  wire  [7:0] Dbus;
  int         n_checks = 0;
  int         n_pass = 0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .Dbus (Dbus),
    .bus  (bus)
  );

  assign Dbus = drv_en ? drv : 8'hzz;

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] val);
    bus.op    = op;
    bus.write = 1'b1;
    drv       = val;
    drv_en    = 1'b1;
    tick();
    bus.write = 1'b0;
    drv_en    = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_acc", bus.Acc, 8'h00);
    chk("reset_ext", bus.Ext, 8'h00);
    chk("reset_flags", bus.flags, 4'h0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    do_op(3'd0, 8'h7F);
    chk("load_acc", bus.Acc, 8'h7F);
    do_op(3'd1, 8'h01);
    chk("add_ovf_acc", bus.Acc, 8'h80);
    chk("add_ovf_flags", bus.flags, 4'b1001);
    do_op(3'd2, 8'h81);
    chk("sub_borrow_acc", bus.Acc, 8'hFF);
    chk("sub_borrow_flags", bus.flags, 4'b1010);
    do_op(3'd1, 8'h01);
    chk("add_carry_acc", bus.Acc, 8'h00);
    chk("add_carry_flags", bus.flags, 4'b0110);
  endtask

  task automatic test_back_to_back();
    do_op(3'd0, 8'hF0);
    do_op(3'd3, 8'h3C);
    chk("and_acc", bus.Acc, 8'h30);
    do_op(3'd4, 8'h0F);
    chk("or_acc", bus.Acc, 8'h3F);
    do_op(3'd5, 8'hFF);
    chk("xor_acc", bus.Acc, 8'hC0);
    chk("xor_flags", bus.flags, 4'b1000);
  endtask

  task automatic test_bus(input logic [7:0] exp_acc, input logic [7:0] exp_ext);
    bus.read = 1'b1;
    bus.read_ext = 1'b1;
    #2;
    chk("bus_read_ext_prio", Dbus, exp_ext);
    bus.read_ext = 1'b0;
    #2;
    chk("bus_read_acc", Dbus, exp_acc);
    bus.read = 1'b0;
    drv = 8'hAA;
    drv_en = 1'b1;
    #2;
    chk("bus_released", Dbus, 8'hAA);
    drv_en = 1'b0;
    tick();
    do_op(3'd0, 8'h55);
    chk("bus_ext_load", bus.Acc, 8'h55);
  endtask

`ifdef ALU_MULDIV_EN
  task automatic wait_done(output int cycles, output logic partial_seen);
    cycles = 0;
    partial_seen = 1'b0;
    while (!bus.done && cycles < 20) begin
      tick();
      cycles++;
      if (!bus.done && bus.busy !== 1'b1) partial_seen = 1'b1;
    end
  endtask

  task automatic test_mul();
    int   cycles;
    logic bad;
    do_op(3'd0, 8'hC8);
    do_op(3'd6, 8'h64);
    chk("mul_busy_start", bus.busy, 1'b1);
    drv = 8'h33;
    drv_en = 1'b1;
    tick();
    tick();
    bus.op = 3'd0;
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    drv_en = 1'b0;
    chk("mul_acc_hidden", bus.Acc, 8'hC8);
    cycles = 3;
    bad = 1'b0;
    while (!bus.done && cycles < 20) begin
      tick();
      cycles++;
      if (!bus.done && (bus.busy !== 1'b1 || bus.Acc !== 8'hC8)) bad = 1'b1;
    end
    chk("mul_latency", cycles, 8);
    chk("mul_no_partial", bad, 1'b0);
    chk("mul_acc", bus.Acc, 8'h20);
    chk("mul_ext", bus.Ext, 8'h4E);
    chk("mul_flags", bus.flags, 4'b0010);
    chk("mul_busy_end", bus.busy, 1'b0);
    tick();
    chk("mul_done_pulse", bus.done, 1'b0);
  endtask

  task automatic test_div();
    int   cycles;
    logic bad;
    do_op(3'd0, 8'hC8);
    do_op(3'd7, 8'h07);
    wait_done(cycles, bad);
    chk("div_latency", cycles, 8);
    chk("div_acc", bus.Acc, 8'h1C);
    chk("div_ext", bus.Ext, 8'h04);
    chk("div_flags", bus.flags, 4'b0000);
    do_op(3'd0, 8'h2A);
    do_op(3'd7, 8'h00);
    wait_done(cycles, bad);
    chk("div0_acc", bus.Acc, 8'hFF);
    chk("div0_ext", bus.Ext, 8'h2A);
    chk("div0_flags", bus.flags, 4'b1001);
    tick();
  endtask

  task automatic test_reset_mid();
    logic done_seen;
    do_op(3'd0, 8'h0F);
    do_op(3'd6, 8'h03);
    tick();
    tick();
    #2;
    nRST = 1'b0;
    #1;
    chk("rmid_acc", bus.Acc, 8'h00);
    chk("rmid_ext", bus.Ext, 8'h00);
    chk("rmid_flags", bus.flags, 4'h0);
    chk("rmid_busy", bus.busy, 1'b0);
    tick();
    nRST = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) done_seen = 1'b1;
    end
    chk("rmid_no_done", done_seen, 1'b0);
    chk("rmid_acc_after", bus.Acc, 8'h00);
  endtask
`else
  task automatic test_no_muldiv();
    logic seen;
    do_op(3'd0, 8'h12);
    do_op(3'd6, 8'h03);
    chk("nomd_mul_acc", bus.Acc, 8'h12);
    chk("nomd_mul_flags", bus.flags, 4'b0000);
    chk("nomd_busy", bus.busy, 1'b0);
    do_op(3'd0, 8'h92);
    do_op(3'd7, 8'h00);
    chk("nomd_div_acc", bus.Acc, 8'h92);
    chk("nomd_div_flags", bus.flags, 4'b1000);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("nomd_no_done", seen, 1'b0);
    chk("nomd_ext", bus.Ext, 8'h00);
    bus.read_ext = 1'b1;
    #2;
    chk("nomd_read_ext", Dbus, 8'h00);
    bus.read_ext = 1'b0;
    tick();
  endtask
`endif

  initial begin
    bus.op = 3'd0;
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.read_ext = 1'b0;
    test_reset();
    test_arith();
    test_back_to_back();
`ifdef ALU_MULDIV_EN
    test_div();
    test_bus(8'hFF, 8'h2A);
    test_mul();
    test_reset_mid();
`else
    test_bus(8'hC0, 8'h00);
    test_no_muldiv();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
